// File: rtl/mux_arb_reg.sv
// Registered N-input multiplexer with valid/ready on every port.
// Selection is either a direct external select or round-robin arbitration.
module mux_arb_reg #(
  parameter  int DATAW = 16,
  parameter  int NCH   = 8,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_rr,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*DATAW-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [DATAW-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  localparam int unsigned NCHU = NCH;

  logic [DATAW-1:0] ch [NCH];
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  cand;
  logic [SELW-1:0]  idx;
  logic             cand_ok;
  logic             load;
  logic             xfer;

  always_comb begin
    for (int unsigned i = 0; i < NCHU; i++) begin
      ch[i] = in_data[i*DATAW +: DATAW];
    end
  end

  assign load = ~out_valid | out_ready;

  // Round-robin search starts one past the last winner, wrapping modulo NCH.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    idx     = '0;
    if (!mode_rr) begin
      if (int'(sel) < NCH) begin
        cand    = sel;
        cand_ok = 1'b1;
      end
    end else begin
      for (int unsigned k = 1; k <= NCHU; k++) begin
        idx = SELW'((32'(ptr) + k) % NCHU);
        if (!cand_ok && in_valid[idx]) begin
          cand    = idx;
          cand_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (cand_ok && load && rst_n) begin
      in_ready[cand] = 1'b1;
    end
  end

  assign xfer = cand_ok & load & in_valid[cand];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(NCH - 1);
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch[cand];
        out_chan  <= cand;
        if (mode_rr) begin
          ptr <= cand;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: an 8-channel instance for the main
// behaviour and a 6-channel instance for out-of-range select.
module tb_mux_arb_reg;

  localparam int DATAW = 16;
  localparam int NCH   = 8;
  localparam int NCH6  = 6;

  logic                 clk;
  logic                 rst_n;
  logic                 mode_rr;
  logic [2:0]           sel;
  logic [NCH*DATAW-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [DATAW-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           out_chan;

  logic                  mode6;
  logic [2:0]            sel6;
  logic [NCH6*DATAW-1:0] data6;
  logic [NCH6-1:0]       valid6;
  logic [NCH6-1:0]       ready6;
  logic [DATAW-1:0]      odata6;
  logic                  ovalid6;
  logic                  oready6;
  logic [2:0]            ochan6;

  int n_tests;
  int n_fail;

  mux_arb_reg #(.DATAW(DATAW), .NCH(NCH)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode_rr(mode_rr), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
  );

  mux_arb_reg #(.DATAW(DATAW), .NCH(NCH6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .mode_rr(mode6), .sel(sel6),
    .in_data(data6), .in_valid(valid6), .in_ready(ready6),
    .out_data(odata6), .out_valid(ovalid6), .out_ready(oready6),
    .out_chan(ochan6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    mode_rr   = 1'b1;
    sel       = '0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) in_data[i*DATAW +: DATAW] = 16'h100 + 16'(i);
    mode6   = 1'b1;
    sel6    = '0;
    valid6  = '0;
    oready6 = 1'b1;
    for (int i = 0; i < NCH6; i++) data6[i*DATAW +: DATAW] = 16'h600 + 16'(i);

    // Reset state with all inputs requesting
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_out_chan",  32'(out_chan),  32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h0);

    // Release in RR: first grant is channel 0, then fair rotation
    rst_n = 1'b1;
    #1;
    check("rr_first_grant", 32'(in_ready), 32'h01);
    tick();
    check("rr_first_chan",  32'(out_chan),  32'h0);
    check("rr_first_data",  32'(out_data),  32'h100);
    check("rr_first_valid", 32'(out_valid), 32'h1);
    for (int i = 1; i < 16; i++) begin
      check("rr_fair_ready", 32'(in_ready), 32'h1 << (i % 8));
      tick();
      check("rr_fair_chan",  32'(out_chan),  32'(i % 8));
      check("rr_fair_data",  32'(out_data),  32'h100 + 32'(i % 8));
      check("rr_fair_valid", 32'(out_valid), 32'h1);
    end

    // Sparse RR: bring ptr to 2, then alternate 7,2,7
    in_valid = 8'h04;
    tick();
    check("sp_setup_chan", 32'(out_chan), 32'h2);
    in_valid = 8'h84;
    #1;
    check("sp_ready_7a", 32'(in_ready), 32'h80);
    tick();
    check("sp_chan_7a", 32'(out_chan), 32'h7);
    check("sp_ready_2", 32'(in_ready), 32'h04);
    tick();
    check("sp_chan_2", 32'(out_chan), 32'h2);
    check("sp_ready_7b", 32'(in_ready), 32'h80);
    tick();
    check("sp_chan_7b", 32'(out_chan), 32'h7);
    in_valid = 8'h04;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sp_only2_ready", 32'(in_ready), 32'h04);
      tick();
      check("sp_only2_chan",  32'(out_chan), 32'h2);
      check("sp_only2_data",  32'(out_data), 32'h102);
    end

    // Backpressure: output frozen, nothing accepted, ptr kept at 2
    in_valid  = 8'h84;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("bp_out_data",  32'(out_data),  32'h102);
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_out_chan",  32'(out_chan),  32'h2);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h80);
    tick();
    check("bp_next_chan",  32'(out_chan),  32'h7);
    check("bp_next_data",  32'(out_data),  32'h107);
    check("bp_next_valid", 32'(out_valid), 32'h1);

    // Direct mode
    mode_rr = 1'b0;
    sel     = 3'd3;
    in_valid = 8'h08;
    in_data[3*DATAW +: DATAW] = 16'hA5A5;
    #1;
    check("dir_ready_3", 32'(in_ready), 32'h08);
    tick();
    check("dir_data",  32'(out_data),  32'hA5A5);
    check("dir_chan",  32'(out_chan),  32'h3);
    check("dir_valid", 32'(out_valid), 32'h1);
    sel = 3'd5;
    #1;
    check("dir_ready_5", 32'(in_ready), 32'h20);
    tick();
    check("dir_nox_valid", 32'(out_valid), 32'h0);
    check("dir_nox_data",  32'(out_data),  32'hA5A5);
    check("dir_nox_chan",  32'(out_chan),  32'h3);

    // Back to RR: ptr still 7 from the last RR transfer
    mode_rr  = 1'b1;
    in_valid = 8'h84;
    #1;
    check("mode_ptr_kept", 32'(in_ready), 32'h04);
    tick();
    check("mode_rr_chan", 32'(out_chan), 32'h2);

    // Async reset between edges drops the held word at once
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data",  32'(out_data),  32'h0);
    check("mid_rst_ready", 32'(in_ready),  32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", 32'(in_ready), 32'h04);
    tick();
    check("post_rst_chan", 32'(out_chan), 32'h2);

    // 6-channel build: out-of-range select gives no candidate
    mode6  = 1'b0;
    sel6   = 3'd6;
    valid6 = 6'h3F;
    #1;
    check("oor6_ready", 32'(ready6), 32'h0);
    tick();
    check("oor6_valid", 32'(ovalid6), 32'h0);
    sel6 = 3'd7;
    #1;
    check("oor7_ready", 32'(ready6), 32'h0);
    tick();
    check("oor7_valid", 32'(ovalid6), 32'h0);
    sel6 = 3'd5;
    #1;
    check("n6_ready_5", 32'(ready6), 32'h20);
    tick();
    check("n6_data", 32'(odata6), 32'h605);
    check("n6_chan", 32'(ochan6), 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised registered N-input multiplexer with a valid/ready handshake on every input and on the output.
- Two selection modes:
  - Direct mode: an external select picks the channel, as in the existing combinational muxes.
  - Round-robin mode: the block arbitrates among requesting channels and rotates priority.
- The result is held in a single output register stage.
- Intended to merge multiple register-file/ALU/memory result sources onto one writeback path.

Parameters:
- DATAW, 16: data width per channel in bits.
- NCH, 8: number of input channels, 2..16.
- SELW, $clog2(NCH): width of sel and out_chan (derived, not overridden).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode_rr  input  1  0 = direct select, 1 = round-robin arbitration.
- sel  input  SELW  channel index used when mode_rr = 0.
- in_data  input  NCH*DATAW  flattened inputs; channel i occupies bits [i*DATAW +: DATAW].
- in_valid  input  NCH  per-channel request.
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- out_data  output  DATAW  registered selected data.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  downstream accept.
- out_chan  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync release): out_valid = 0, out_data = 0, out_chan = 0, rr pointer ptr = NCH-1. All in_ready read 0 while rst_n = 0.
- load = ~out_valid | out_ready. The output register may be written this cycle (pipelined, no bubble).
- Direct mode (mode_rr = 0):
  - Candidate is sel.
  - If sel >= NCH there is no candidate and all in_ready = 0.
  - in_ready[sel] = load. in_ready does not depend on in_valid.
- Round-robin mode (mode_rr = 1):
  - Search channels ptr+1, ptr+2, … modulo NCH; the first with in_valid = 1 is the winner.
  - in_ready[winner] = load. No valid channel means no winner and all in_ready = 0.
- Transfer: occurs for candidate/winner c when in_valid[c] & in_ready[c]. On the next edge: out_data <= in_data[c], out_chan <= c, out_valid <= 1.
  - In RR mode, ptr <= c on transfer only. ptr is unchanged in direct mode and on cycles with no transfer.
- Load with no transfer: out_valid <= 0; out_data and out_chan hold their last values.
- No load (out_valid = 1, out_ready = 0): output register, ptr and all in_ready are frozen/low; no input is consumed.
- Latency: exactly 1 cycle from input handshake to out_valid. Sustained throughput is 1 word/cycle when out_ready = 1.
- Fairness: in RR mode with all NCH channels continuously valid and out_ready = 1, grants cycle 0,1,…,NCH-1,0,… with no repeats inside a window of NCH transfers.
- Mode change: takes effect on the same cycle's combinational selection. ptr is retained across mode changes. An in-flight output word is unaffected.
- Reset mid-operation: the held output word is discarded and out_valid drops asynchronously. After release, the first RR grant goes to the lowest-index valid channel.
- Simultaneous input transfer and output take: legal. The new word replaces the old one with out_valid staying 1.
- No combinational path from out_ready to out_data/out_valid. The only comb path is from out_ready/in_valid/sel/mode_rr to in_ready.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 8'hFF and out_ready = 1 -> out_valid = 0, out_data = 0, in_ready = 0. Release rst_n in RR mode -> first grant in_ready = 8'h01, next cycle out_chan = 0.
- Direct mode: mode_rr = 0, sel = 3, in_valid = 8'h08, in_data ch3 = 16'hA5A5, out_ready = 1 -> in_ready = 8'h08, next cycle out_data = 16'hA5A5, out_chan = 3, out_valid = 1. Then set sel = 5 with in_valid[5] = 0 -> out_valid drops after 1 cycle.
- Round-robin fairness: mode_rr = 1, in_valid = 8'hFF, ch i data = i+16'h100, out_ready = 1 for 16 cycles -> out_chan sequence 0..7,0..7 and out_data 16'h100..16'h107 twice, with no gaps.
- Sparse RR: in_valid = 8'b1000_0100 with ptr = 2 -> grant ch7, then ch2, then ch7. Drop ch7 -> ch2 is granted every cycle.
- Backpressure: out_ready = 0 for 4 cycles while out_valid = 1 -> out_data stable, in_ready = 0, ptr unchanged. On out_ready = 1, the held word is taken and the next grant is loaded in the same cycle.
- Mid-operation reset and mode switch: pulse rst_n low asynchronously between edges while out_valid = 1 -> out_valid = 0 immediately. Then switch mode_rr 1->0 with sel = 6 (out-of-range case: NCH = 6 build) -> in_ready = 0 and out_valid stays 0.
